// File: rtl/scan_sequencer_if.sv
// ---------------------------------------------------------------------------
// scan_sequencer_if
// Bundles the control inputs and raster/status outputs of scan_sequencer.
//   slave  modport : used by scan_sequencer (inputs in, raster/status out)
//   master modport : used by whoever drives the sequencer (testbench, top)
// Signals:
//   iStart       level, begins a boundary search from IDLE
//   iEdgeDone    [0] top/bottom found, [1] left/right found
//   iVGA_Read    VGA pixel request, advances the raster in DISPLAY
//   iFrameStart  one-cycle pulse at VGA X=0,Y=0
//   iRescan      one-cycle pulse requesting a new boundary search
//   oRow/oCol    current raster position
//   oAddr        oRow*H_ACTIVE + oCol
//   oHscan/oVscan, oEnEdge, oEnRecog, oTimeout, oState  status
// ---------------------------------------------------------------------------
interface scan_sequencer_if;
    logic        iStart;
    logic [1:0]  iEdgeDone;
    logic        iVGA_Read;
    logic        iFrameStart;
    logic        iRescan;
    logic [9:0]  oRow;
    logic [9:0]  oCol;
    logic [18:0] oAddr;
    logic        oHscan;
    logic        oVscan;
    logic        oEnEdge;
    logic        oEnRecog;
    logic        oTimeout;
    logic [2:0]  oState;

    modport slave (
        input  iStart, iEdgeDone, iVGA_Read, iFrameStart, iRescan,
        output oRow, oCol, oAddr, oHscan, oVscan, oEnEdge, oEnRecog,
               oTimeout, oState
    );

    modport master (
        output iStart, iEdgeDone, iVGA_Read, iFrameStart, iRescan,
        input  oRow, oCol, oAddr, oHscan, oVscan, oEnEdge, oEnRecog,
               oTimeout, oState
    );
endinterface

// File: rtl/scan_sequencer.sv
// ---------------------------------------------------------------------------
// scan_sequencer
// Raster address sequencer for a boundary search followed by display.
//   IDLE    : counters held at 0, waits for iStart
//   HSCAN   : row-major sweep until iEdgeDone[0]
//   VSCAN   : column-major sweep until iEdgeDone == 2'b11
//   DISPLAY : row-major advance on iVGA_Read, realigned by iFrameStart,
//             iRescan restarts the search
// Each search phase may sweep the frame at most MAX_PASSES times; the sweep
// that would complete the last allowed pass returns to IDLE with the sticky
// oTimeout flag set.
// Ports:
//   CLK  system clock (rising edge)
//   RST  asynchronous active-low reset
//   bus  scan_sequencer_if.slave (see interface file for signal list)
// ---------------------------------------------------------------------------
module scan_sequencer #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int MAX_PASSES = 4
) (
    input  logic              CLK,
    input  logic              RST,
    scan_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HSCAN   = 3'd1,
        VSCAN   = 3'd2,
        DISPLAY = 3'd3
    } state_t;

    localparam int PW = $clog2(MAX_PASSES + 1);
    localparam logic [9:0]    COL_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0]    ROW_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [PW-1:0] PASS_LAST = PW'(MAX_PASSES - 1);

    state_t        state_q, state_d;
    logic [9:0]    row_q, row_d;
    logic [9:0]    col_q, col_d;
    logic [PW-1:0] pass_q, pass_d;
    logic          timeout_q, timeout_d;

    logic col_last, row_last, frame_last, pass_expired;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            pass_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;

        col_last     = (col_q == COL_LAST);
        row_last     = (row_q == ROW_LAST);
        frame_last   = col_last && row_last;
        // The wrap that would bring the pass count to MAX_PASSES ends the phase.
        pass_expired = frame_last && (pass_q == PASS_LAST);

        unique case (state_q)
            IDLE: begin
                row_d  = '0;
                col_d  = '0;
                pass_d = '0;
                if (bus.iStart) begin
                    state_d   = HSCAN;
                    timeout_d = 1'b0;
                end
            end

            HSCAN: begin
                // Edge found wins over a same-cycle wrap or expiry.
                if (bus.iEdgeDone[0]) begin
                    state_d = VSCAN;
                    row_d   = '0;
                    col_d   = '0;
                    pass_d  = '0;
                end else if (pass_expired) begin
                    state_d   = IDLE;
                    row_d     = '0;
                    col_d     = '0;
                    pass_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    if (col_last) begin
                        col_d = '0;
                        row_d = row_last ? '0 : row_q + 10'd1;
                    end else begin
                        col_d = col_q + 10'd1;
                    end
                    if (frame_last) begin
                        pass_d = pass_q + PW'(1);
                    end
                end
            end

            VSCAN: begin
                if (bus.iEdgeDone == 2'b11) begin
                    state_d = DISPLAY;
                    row_d   = '0;
                    col_d   = '0;
                    pass_d  = '0;
                end else if (pass_expired) begin
                    state_d   = IDLE;
                    row_d     = '0;
                    col_d     = '0;
                    pass_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    if (row_last) begin
                        row_d = '0;
                        col_d = col_last ? '0 : col_q + 10'd1;
                    end else begin
                        row_d = row_q + 10'd1;
                    end
                    if (frame_last) begin
                        pass_d = pass_q + PW'(1);
                    end
                end
            end

            DISPLAY: begin
                pass_d = '0;
                if (bus.iRescan) begin
                    state_d = HSCAN;
                    row_d   = '0;
                    col_d   = '0;
                end else if (bus.iFrameStart) begin
                    row_d = '0;
                    col_d = '0;
                end else if (bus.iVGA_Read) begin
                    if (col_last) begin
                        col_d = '0;
                        row_d = row_last ? '0 : row_q + 10'd1;
                    end else begin
                        col_d = col_q + 10'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                row_d   = '0;
                col_d   = '0;
                pass_d  = '0;
            end
        endcase
    end

    assign bus.oRow     = row_q;
    assign bus.oCol     = col_q;
    assign bus.oAddr    = 19'(row_q) * 19'(H_ACTIVE) + 19'(col_q);
    assign bus.oState   = state_q;
    assign bus.oHscan   = (state_q != VSCAN);
    assign bus.oVscan   = (state_q == VSCAN);
    assign bus.oEnEdge  = (state_q == HSCAN) || (state_q == VSCAN);
    assign bus.oEnRecog = (state_q == DISPLAY);
    assign bus.oTimeout = timeout_q;

endmodule
